// File: rtl/vls_unit_if.sv
// rtl/vls_unit_if.sv - command, register-file and memory bus bundle for vls_unit
interface vls_unit_if #(
  parameter int LANES      = 4,
  parameter int VREGS      = 32,
  parameter int VREG_WIDTH = 32,
  parameter int ADDR_W     = 32
);
  localparam int IDX_W = $clog2(VREGS);

  logic                                cmd_valid;
  logic                                cmd_ready;
  logic                                cmd_store;
  logic [IDX_W-1:0]                    cmd_vreg;
  logic [ADDR_W-1:0]                   cmd_addr;
  logic [ADDR_W-1:0]                   cmd_stride;
  logic                                busy;
  logic                                done_valid;
  logic                                vrf_rd_valid;
  logic [IDX_W-1:0]                    vrf_rd_idx;
  logic [LANES-1:0][VREG_WIDTH-1:0]    vrf_rd_data;
  logic                                vrf_rd_ready;
  logic                                vrf_wr_valid;
  logic [IDX_W-1:0]                    vrf_wr_idx;
  logic [LANES-1:0][VREG_WIDTH-1:0]    vrf_wr_data;
  logic                                vrf_wr_ready;
  logic                                mem_req_valid;
  logic                                mem_req_ready;
  logic                                mem_req_we;
  logic [ADDR_W-1:0]                   mem_req_addr;
  logic [VREG_WIDTH-1:0]               mem_req_wdata;
  logic                                mem_rsp_valid;
  logic [VREG_WIDTH-1:0]               mem_rsp_rdata;

  // Sequencer side
  modport master (
    input  cmd_valid, cmd_store, cmd_vreg, cmd_addr, cmd_stride,
    input  vrf_rd_data, vrf_rd_ready, vrf_wr_ready,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    output cmd_ready, busy, done_valid,
    output vrf_rd_valid, vrf_rd_idx, vrf_wr_valid, vrf_wr_idx, vrf_wr_data,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
  );

  // Issue stage, register file and memory side
  modport slave (
    output cmd_valid, cmd_store, cmd_vreg, cmd_addr, cmd_stride,
    output vrf_rd_data, vrf_rd_ready, vrf_wr_ready,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    input  cmd_ready, busy, done_valid,
    input  vrf_rd_valid, vrf_rd_idx, vrf_wr_valid, vrf_wr_idx, vrf_wr_data,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
  );
endinterface

// File: rtl/vls_unit.sv
// rtl/vls_unit.sv - vector load/store sequencer; VLS_STRIDE_EN enables per-command byte stride
module vls_unit #(
  parameter int LANES      = 4,
  parameter int VREGS      = 32,
  parameter int VREG_WIDTH = 32,
  parameter int ADDR_W     = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  vls_unit_if.master bus
);
  localparam int IDX_W = $clog2(VREGS);
  localparam int CNT_W = $clog2(LANES + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LANES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LANES - 1);

  typedef logic [LANES-1:0][VREG_WIDTH-1:0] vec_t;
  typedef enum logic [2:0] {IDLE, LD_REQ, LD_WB, ST_RD, ST_WR} state_t;

  state_t            state;
  logic [CNT_W-1:0]  iss;
  logic [CNT_W-1:0]  rsp;
  logic [IDX_W-1:0]  vreg_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] stride_w;
  vec_t              lane_buf;
  vec_t              ld_shift;
  vec_t              st_shift;

`ifdef VLS_STRIDE_EN
  logic [ADDR_W-1:0] stride_q;
  assign stride_w = stride_q;
`else
  logic unused_stride;
  assign stride_w      = ADDR_W'(VREG_WIDTH / 8);
  assign unused_stride = ^bus.cmd_stride;
`endif

  // Lane buffer works as a shift register: loads enter at the top lane so the
  // first response ends in lane 0; stores always drive lane 0 to memory.
  always_comb begin
    ld_shift = lane_buf >> VREG_WIDTH;
    ld_shift[LANES-1] = bus.mem_rsp_rdata;
    st_shift = lane_buf >> VREG_WIDTH;
  end

  // Outputs decoded from registered state; done follows the final handshake
  assign bus.cmd_ready     = (state == IDLE);
  assign bus.busy          = (state != IDLE);
  assign bus.vrf_rd_valid  = (state == ST_RD);
  assign bus.vrf_rd_idx    = vreg_q;
  assign bus.vrf_wr_valid  = (state == LD_WB);
  assign bus.vrf_wr_idx    = vreg_q;
  assign bus.vrf_wr_data   = lane_buf;
  assign bus.mem_req_valid = ((state == LD_REQ) && (iss != CNT_FULL)) || (state == ST_WR);
  assign bus.mem_req_we    = (state == ST_WR);
  assign bus.mem_req_addr  = addr_q;
  assign bus.mem_req_wdata = lane_buf[0];
  assign bus.done_valid    = ((state == LD_WB) && bus.vrf_wr_ready) ||
                             ((state == ST_WR) && bus.mem_req_ready && (iss == CNT_LAST));

  // Sequencer FSM: command latch, issue/response counting, buffer movement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      iss      <= '0;
      rsp      <= '0;
      vreg_q   <= '0;
      addr_q   <= '0;
      lane_buf <= '0;
`ifdef VLS_STRIDE_EN
      stride_q <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            vreg_q <= bus.cmd_vreg;
            addr_q <= bus.cmd_addr;
            iss    <= '0;
            rsp    <= '0;
`ifdef VLS_STRIDE_EN
            stride_q <= bus.cmd_stride;
`endif
            state  <= bus.cmd_store ? ST_RD : LD_REQ;
          end
        end
        LD_REQ: begin
          if (bus.mem_req_valid && bus.mem_req_ready) begin
            iss    <= iss + 1'b1;
            addr_q <= addr_q + stride_w;
          end
          if (bus.mem_rsp_valid && (rsp != CNT_FULL)) begin
            lane_buf <= ld_shift;
            rsp      <= rsp + 1'b1;
            if (rsp == CNT_LAST) state <= LD_WB;
          end
        end
        LD_WB: begin
          if (bus.vrf_wr_ready) state <= IDLE;
        end
        ST_RD: begin
          if (bus.vrf_rd_ready) begin
            lane_buf <= bus.vrf_rd_data;
            state    <= ST_WR;
          end
        end
        ST_WR: begin
          if (bus.mem_req_ready) begin
            lane_buf <= st_shift;
            iss      <= iss + 1'b1;
            addr_q   <= addr_q + stride_w;
            if (iss == CNT_LAST) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vls_unit.sv
// tb/tb_vls_unit.sv - scoreboard bench for vls_unit
module tb_vls_unit;
  typedef logic [3:0][31:0] vec_t;
  typedef struct {logic [31:0] addr; logic we; logic [31:0] wdata;} mem_exp_t;
  typedef struct {logic [4:0] idx; vec_t data;} vrf_exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   last_done_cyc = 0;
  int   rsp_seen = 0;
  int   mem_stall = 0;
  int   mem_wait = 0;
  int   wr_stall = 0;
  int   wr_wait = 0;
  logic [31:0] stride_exp;

  mem_exp_t    exp_mem[$];
  vrf_exp_t    exp_vrf[$];
  logic [31:0] rsp_q[$];
  vec_t        vrf_m[32];

  vls_unit_if #(.LANES(4), .VREGS(32), .VREG_WIDTH(32), .ADDR_W(32)) bus ();

  vls_unit #(.LANES(4), .VREGS(32), .VREG_WIDTH(32), .ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.vrf_rd_data = vrf_m[bus.vrf_rd_idx];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory and register-file responders, driven just after each rising edge
  always @(posedge clk) begin
    #1;
    if (rsp_q.size() != 0) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_rdata = rsp_q.pop_front();
    end else begin
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_rdata = '0;
    end
    if (bus.mem_req_valid && mem_wait < mem_stall) begin
      bus.mem_req_ready = 1'b0;
      mem_wait++;
    end else bus.mem_req_ready = 1'b1;
    if (bus.vrf_wr_valid && wr_wait < wr_stall) begin
      bus.vrf_wr_ready = 1'b0;
      wr_wait++;
    end else bus.vrf_wr_ready = 1'b1;
  end

  // Monitor: compare requests/writes against the scoreboard at mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_req_valid) begin
        chk("req_expected", exp_mem.size() != 0, 1);
        if (exp_mem.size() != 0) begin
          chk("req_addr", bus.mem_req_addr, exp_mem[0].addr);
          chk("req_we", bus.mem_req_we, exp_mem[0].we);
          if (exp_mem[0].we) chk("req_wdata", bus.mem_req_wdata, exp_mem[0].wdata);
        end
        if (bus.mem_req_ready) begin
          mem_wait = 0;
          if (exp_mem.size() != 0) void'(exp_mem.pop_front());
          if (!bus.mem_req_we) rsp_q.push_back(bus.mem_req_addr + 32'd1);
        end
      end
      if (bus.mem_rsp_valid) rsp_seen++;
      if (bus.vrf_wr_valid) begin
        chk("wr_expected", exp_vrf.size() != 0, 1);
        chk("wr_busy", bus.cmd_ready, 0);
        if (exp_vrf.size() != 0) begin
          chk("wr_idx", bus.vrf_wr_idx, exp_vrf[0].idx);
          chk("wr_data", bus.vrf_wr_data, exp_vrf[0].data);
        end
        if (bus.vrf_wr_ready) begin
          wr_wait = 0;
          vrf_m[bus.vrf_wr_idx] = bus.vrf_wr_data;
          if (exp_vrf.size() != 0) void'(exp_vrf.pop_front());
        end
      end
      if (bus.done_valid) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
    end
  end

  task automatic push_mem(input logic [31:0] base, input logic [31:0] stride,
                          input logic we, input vec_t data);
    mem_exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.addr  = base + i * stride;
      e.we    = we;
      e.wdata = data[i];
      exp_mem.push_back(e);
    end
  endtask

  task automatic push_load(input logic [4:0] vreg, input logic [31:0] base, input logic [31:0] stride);
    vrf_exp_t v;
    vec_t d;
    for (int i = 0; i < 4; i++) d[i] = base + i * stride + 32'd1;
    push_mem(base, stride, 1'b0, '0);
    v.idx  = vreg;
    v.data = d;
    exp_vrf.push_back(v);
  endtask

  task automatic drive_cmd(input logic store, input logic [4:0] vreg,
                           input logic [31:0] addr, input logic [31:0] stride, output int acc);
    @(posedge clk); #1;
    bus.cmd_valid  = 1'b1;
    bus.cmd_store  = store;
    bus.cmd_vreg   = vreg;
    bus.cmd_addr   = addr;
    bus.cmd_stride = stride;
    acc = cyc;
    @(posedge clk); #1;
    bus.cmd_valid  = 1'b0;
  endtask

  task automatic run_cmd(input string tag, input logic store, input logic [4:0] vreg,
                         input logic [31:0] addr, input logic [31:0] stride, input int lat);
    int acc;
    int d0;
    int n;
    d0 = done_cnt;
    chk({tag, "_idle"}, bus.cmd_ready, 1);
    drive_cmd(store, vreg, addr, stride, acc);
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      @(negedge clk); #2;
      n++;
    end
    chk({tag, "_done_seen"}, done_cnt != d0, 1);
    chk({tag, "_done_cycle"}, last_done_cyc - acc, lat);
    @(negedge clk); #2;
    chk({tag, "_ready_after"}, bus.cmd_ready, 1);
    chk({tag, "_busy_after"}, bus.busy, 0);
    repeat (2) @(negedge clk);
    #2;
    chk({tag, "_one_done"}, done_cnt - d0, 1);
    chk({tag, "_mem_drained"}, exp_mem.size(), 0);
    chk({tag, "_vrf_drained"}, exp_vrf.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done_valid, 0);
    chk({tag, "_rd_valid"}, bus.vrf_rd_valid, 0);
    chk({tag, "_wr_valid"}, bus.vrf_wr_valid, 0);
    chk({tag, "_req_valid"}, bus.mem_req_valid, 0);
    chk({tag, "_req_we"}, bus.mem_req_we, 0);
    chk({tag, "_req_addr"}, bus.mem_req_addr, 0);
    chk({tag, "_req_wdata"}, bus.mem_req_wdata, 0);
    chk({tag, "_wr_data"}, bus.vrf_wr_data, 0);
    chk({tag, "_rd_idx"}, bus.vrf_rd_idx, 0);
    chk({tag, "_wr_idx"}, bus.vrf_wr_idx, 0);
  endtask

  initial begin
    int acc;
    int n;
    int d0;
    vec_t v3;
    vec_t v7;
`ifdef VLS_STRIDE_EN
    stride_exp = 32'h40;
`else
    stride_exp = 32'h4;
`endif
    for (int i = 0; i < 32; i++) vrf_m[i] = '0;
    for (int i = 0; i < 4; i++) begin
      v3[i] = i + 1;
      v7[i] = 32'h70 + i;
    end
    vrf_m[3] = v3;
    vrf_m[7] = v7;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_store = 1'b0; bus.cmd_vreg = '0;
    bus.cmd_addr = '0; bus.cmd_stride = '0;
    bus.vrf_rd_ready = 1'b1; bus.vrf_wr_ready = 1'b1; bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b0; bus.mem_rsp_rdata = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Unit-stride load, zero-stall memory answering one cycle after request
    push_load(5'd5, 32'h100, 32'h4);
    run_cmd("load_basic", 1'b0, 5'd5, 32'h100, 32'h0, 6);
    chk("load_basic_vreg5", vrf_m[5], {32'h10D, 32'h109, 32'h105, 32'h101});

    // Store with memory ready low two cycles per request
    mem_stall = 2;
    push_mem(32'h200, 32'h4, 1'b1, v3);
    run_cmd("store_stall", 1'b1, 5'd3, 32'h200, 32'h0, 13);
    mem_stall = 0;

    // Strided store (stride ignored unless enabled), zero-wait timing
    push_mem(32'h1000, stride_exp, 1'b1, v3);
    run_cmd("store_stride", 1'b1, 5'd3, 32'h1000, 32'h40, 5);

    // Address wrap-around
    push_load(5'd9, 32'hFFFF_FFF8, 32'h4);
    run_cmd("load_wrap", 1'b0, 5'd9, 32'hFFFF_FFF8, 32'h0, 6);

    // Register-file write back-pressure for three cycles
    wr_stall = 3;
    push_load(5'd10, 32'h300, 32'h4);
    run_cmd("load_wrstall", 1'b0, 5'd10, 32'h300, 32'h0, 9);
    wr_stall = 0;

    // Reset after two load responses abandons the command
    d0 = done_cnt;
    n = rsp_seen;
    push_load(5'd7, 32'h400, 32'h4);
    drive_cmd(1'b0, 5'd7, 32'h400, 32'h0, acc);
    while (rsp_seen < n + 2 && cyc < acc + 50) begin
      @(negedge clk); #2;
    end
    chk("abort_two_rsp", rsp_seen - n, 2);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    exp_mem.delete();
    exp_vrf.delete();
    rsp_q.delete();
    mem_wait = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("abort_no_done", done_cnt, d0);
    chk("abort_vreg7_model", vrf_m[7], v7);
    push_mem(32'h500, 32'h4, 1'b1, v7);
    run_cmd("after_abort", 1'b1, 5'd7, 32'h500, 32'h0, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/vls_unit.md
# vls_unit

Vector load/store sequencer for the mini-GPU. Acts as the initiator on the vector register file's read and write ports, and moves one whole vector register (LANES words) to or from a word-wide memory port. Sits between the instruction issue stage, which sends one command per vector load or store, and the shared memory/cache request port.

## Interface
Parameters:
- LANES, 4, words per vector register; ≥1
- VREGS, 32, number of vector registers
- VREG_WIDTH, 32, bits per lane word; multiple of 8
- ADDR_W, 32, byte-address width

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  unit idle, accepts command
- cmd_store  in  1  1 = store vreg to memory, 0 = load memory to vreg
- cmd_vreg  in  $clog2(VREGS)  vector register index
- cmd_addr  in  ADDR_W  base byte address
- cmd_stride  in  ADDR_W  byte stride between lanes (used only with VLS_STRIDE_EN)
- busy  out  1  command in progress
- done_valid  out  1  one-cycle completion pulse
- vrf_rd_valid  out  1  register read request
- vrf_rd_idx  out  $clog2(VREGS)  read index
- vrf_rd_data  in  VREG_WIDTH×[LANES]  read data (combinational from register file)
- vrf_rd_ready  in  1  read data valid
- vrf_wr_valid  out  1  register write request
- vrf_wr_idx  out  $clog2(VREGS)  write index
- vrf_wr_data  out  VREG_WIDTH×[LANES]  write data
- vrf_wr_ready  in  1  write accepted
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  1 = write
- mem_req_addr  out  ADDR_W  byte address
- mem_req_wdata  out  VREG_WIDTH  write data
- mem_rsp_valid  in  1  read response (in order, loads only)
- mem_rsp_rdata  in  VREG_WIDTH  read response data

## Operation
- FSM states: IDLE, LD_REQ, LD_WB, ST_RD, ST_WR.
- IDLE: cmd_ready=1. On cmd_valid, latch vreg, base, stride, and direction. Go to LD_REQ (load) or ST_RD (store). Clear the issue count (iss) and response count (rsp).
- LD_REQ: mem_req_valid=1 while iss<LANES. Fields: mem_req_we=0, addr = base + iss*stride. iss increments on each handshake. Each mem_rsp_valid writes lane buffer[rsp] and increments rsp. Responses may overlap issue, up to LANES outstanding. When rsp reaches LANES, go to LD_WB.
- LD_WB: vrf_wr_valid=1 with vrf_wr_idx=vreg and vrf_wr_data=buffer. Hold until vrf_wr_ready. On the handshake, pulse done_valid and go to IDLE.
- ST_RD: vrf_rd_valid=1 with vrf_rd_idx=vreg. On vrf_rd_ready, capture vrf_rd_data into buffer and go to ST_WR.
- ST_WR: mem_req_valid=1 with mem_req_we=1, addr = base + iss*stride, wdata = buffer[iss]. Stores expect no response. On the handshake that makes iss=LANES, pulse done_valid and go to IDLE.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is silent. iss and rsp are $clog2(LANES+1) bits wide.
- mem_rsp_valid outside LD_REQ is ignored. Responses beyond LANES are ignored.
- Request fields stay stable while mem_req_valid=1 and mem_req_ready=0.

## Timing
- Reset values: cmd_ready=1, busy=0, done_valid=0, vrf_rd_valid=0, vrf_wr_valid=0, mem_req_valid=0, mem_req_we=0. All index, address, and data outputs 0. Buffer cleared, state IDLE.
- Reset asserted mid-command: the command is abandoned and no done pulse is produced. Outputs return to their reset values asynchronously.
- busy = !cmd_ready. cmd_ready returns high the cycle after done_valid.
- Store, zero-wait memory: accept at cycle 0, ST_RD at 1, memory writes at 2..LANES+1. done_valid coincides with the last write. cmd_ready=1 at LANES+2.
- Load, memory responds one cycle after accept: requests at 1..LANES, responses at 2..LANES+1, write-back with done_valid at LANES+2. cmd_ready=1 at LANES+3.
- A new command is never accepted in the cycle done_valid is high.

## Configuration
- VLS_STRIDE_EN defined: lane address = base + i*cmd_stride. cmd_stride is latched at accept; stride 0 is legal and gives repeated accesses to the same address.
- VLS_STRIDE_EN undefined: stride is fixed at VREG_WIDTH/8 (unit-stride) and cmd_stride is ignored.

## Test plan
- Load, defaults, memory word at address A holds A+1, base 0x100, vreg 5 → requests at 0x100/104/108/10C. vrf write of idx 5 with data {0x101,0x105,0x109,0x10D}. done pulse at cycle 6.
- Store vreg 3 holding {1,2,3,4} to 0x200, memory ready held low for 2 cycles per request → writes 0x200=1 … 0x20C=4 in order. Fields stable while stalled; one done pulse.
- Address wrap: load at base 0xFFFFFFF8 → addresses FFFFFFF8, FFFFFFFC, 00000000, 00000004.
- VLS_STRIDE_EN, stride 0x40, store at 0x1000 → addresses 0x1000/1040/1080/10C0. Without the macro, the same command → 0x1000/1004/1008/100C.
- vrf_wr_ready held low 3 cycles in LD_WB → vrf_wr_valid held with stable data. done pulses on the handshake; cmd_ready stays 0 until then.
- Reset asserted after 2 load responses → all outputs at reset values. A following store completes normally, and the vreg targeted by the abandoned load is unchanged.
